m_7seg_disp_arb: RTL and testbench

//   Arbiter and scan scheduler for the 8-digit seven-segment display.

---
 rtl/m_7seg_disp_arb.sv | 164 ++++++++++++++++
 tb/tb_m_7seg_disp_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_7seg_disp_arb.sv
`default_nettype none
// ============================================================================
//  Module   : m_7seg_disp_arb
//  Purpose  : Two-port round-robin arbiter with post-grant hold for a shared
//             8-digit seven-segment display value, plus the digit scan
//             sequencer (active-low anode select and hex nibble output).
//  Revision : 1.0 - initial release
// ============================================================================
module m_7seg_disp_arb #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic [7:0]  mask0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic [7:0]  mask1,
  output logic        gnt1,
  output logic        busy,
  output logic        disp_owner,
  output logic [3:0]  disp_nibble,
  output logic [7:0]  disp_anode
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t          state_q;
  logic            winner_q;
  logic            rr_ptr_q;
  logic [HW-1:0]   hold_cnt_q;
  logic            gnt0_q;
  logic            gnt1_q;
  logic            busy_q;
  logic            owner_q;
  logic [31:0]     disp_reg_q;
  logic [7:0]      mask_reg_q;

  logic [SCW-1:0]  scan_cnt_q;
  logic [SCW-1:0]  scan_cnt_d;
  logic [2:0]      digit_q;
  logic [2:0]      digit_d;
  logic [3:0]      nibble_q;
  logic [7:0]      anode_q;

  logic            both_req;
  logic            win_d;
  logic [31:0]     wr_data;
  logic [7:0]      wr_mask;

  // Winner selection and write-data mux for the granted requester
  always_comb begin
    both_req = req0 & req1;
    win_d    = both_req ? rr_ptr_q : req1;
    wr_data  = winner_q ? data1 : data0;
    wr_mask  = winner_q ? mask1 : mask0;
  end

  // Arbitration FSM: latch winner, one-cycle grant, commit write, then hold off
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      winner_q   <= 1'b0;
      rr_ptr_q   <= 1'b0;
      hold_cnt_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= 1'b0;
      disp_reg_q <= 32'h0;
      mask_reg_q <= 8'hFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0 | req1) begin
            state_q  <= ST_GRANT;
            winner_q <= win_d;
            gnt0_q   <= ~win_d;
            gnt1_q   <= win_d;
            busy_q   <= 1'b1;
            // Pointer only moves on contention, handing priority to the loser
            if (both_req) begin
              rr_ptr_q <= ~win_d;
            end
          end
        end
        ST_GRANT: begin
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          disp_reg_q <= wr_data;
          mask_reg_q <= wr_mask;
          owner_q    <= winner_q;
          hold_cnt_q <= HOLD_LAST;
          if (HOLD_CYCLES == 0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - HW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next scan position: slot counter wraps at terminal count and advances the digit
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCW'(1);
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 3'd1;
    end
  end

  // Free-running scan; outputs registered so a mid-slot update cannot glitch the anode
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= 3'd0;
      nibble_q   <= 4'h0;
      anode_q    <= 8'hFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      nibble_q   <= disp_reg_q[{digit_q, 2'b00} +: 4];
      anode_q    <= mask_reg_q[digit_q] ? ~(8'b1 << digit_q) : 8'hFF;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign busy        = busy_q;
  assign disp_owner  = owner_q;
  assign disp_nibble = nibble_q;
  assign disp_anode  = anode_q;

endmodule
`default_nettype wire

// File: tb/tb_m_7seg_disp_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_7seg_disp_arb
//  Purpose  : Self-checking bench for the display arbiter / scan sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m_7seg_disp_arb;

  localparam int SD = 4;
  localparam int HC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (HOLD_CYCLES=3)
  logic        rst, req0, req1;
  logic [31:0] data0, data1;
  logic [7:0]  mask0, mask1;
  logic        gnt0, gnt1, busy, disp_owner;
  logic [3:0]  disp_nibble;
  logic [7:0]  disp_anode;

  // Second instance (HOLD_CYCLES=0)
  logic        rst_b, req0_b, req1_b;
  logic [31:0] data0_b, data1_b;
  logic [7:0]  mask0_b, mask1_b;
  logic        gnt0_b, gnt1_b, busy_b, owner_b;
  logic [3:0]  nibble_b;
  logic [7:0]  anode_b;

  m_7seg_disp_arb #(.SCAN_DIV(SD), .HOLD_CYCLES(HC)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .mask0(mask0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .mask1(mask1), .gnt1(gnt1),
    .busy(busy), .disp_owner(disp_owner),
    .disp_nibble(disp_nibble), .disp_anode(disp_anode)
  );

  m_7seg_disp_arb #(.SCAN_DIV(SD), .HOLD_CYCLES(0)) u_dut_h0 (
    .clk(clk), .rst(rst_b),
    .req0(req0_b), .data0(data0_b), .mask0(mask0_b), .gnt0(gnt0_b),
    .req1(req1_b), .data1(data1_b), .mask1(mask1_b), .gnt1(gnt1_b),
    .busy(busy_b), .disp_owner(owner_b),
    .disp_nibble(nibble_b), .disp_anode(anode_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  // Arbiter is modelled as "busy for HC+1 cycles after each grant"; the scan
  // is modelled from the number of clock edges elapsed since reset.
  int          m_rem, m_n;
  logic        m_ptr, m_owner, m_pend, m_pw;
  logic [31:0] m_disp, m_pdata;
  logic [7:0]  m_mask, m_pmask;
  logic        e_g0, e_g1, e_busy;
  logic [3:0]  e_nib;
  logic [7:0]  e_an;

  task automatic model_edge();
    int d;
    logic w;
    if (rst) begin
      m_rem = 0; m_n = 0; m_ptr = 1'b0; m_owner = 1'b0; m_pend = 1'b0;
      m_disp = 32'h0; m_mask = 8'hFF;
      e_g0 = 1'b0; e_g1 = 1'b0; e_nib = 4'h0; e_an = 8'hFF;
    end else begin
      d     = (m_n / SD) % 8;
      e_nib = m_disp[4*d +: 4];
      e_an  = m_mask[d] ? ~(8'b1 << d) : 8'hFF;
      m_n++;
      e_g0 = 1'b0; e_g1 = 1'b0;
      if (m_pend) begin
        m_disp = m_pdata; m_mask = m_pmask; m_owner = m_pw; m_pend = 1'b0;
      end
      if (m_rem == 0 && (req0 || req1)) begin
        w = (req0 && req1) ? m_ptr : req1;
        if (req0 && req1) m_ptr = ~w;
        m_pend  = 1'b1;
        m_pw    = w;
        m_pdata = w ? data1 : data0;
        m_pmask = w ? mask1 : mask0;
        e_g0    = ~w;
        e_g1    = w;
        m_rem   = HC + 1;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
    e_busy = (m_rem > 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("gnt_excl", gnt0 & gnt1, 1'b0);
    chk("busy", busy, e_busy);
    chk("owner", disp_owner, m_owner);
    chk("nibble", disp_nibble, e_nib);
    chk("anode", disp_anode, e_an);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) cycle();
    chk("idle_timeout", busy, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] d0;
    logic [7:0]  m0;
    logic        r1;
    logic [31:0] d1;
    logic [7:0]  m1;
    logic        eg0;
    logic        eg1;
    logic        ebusy;
  } vec_t;

  vec_t tbl[8];

  int          g0q[$];
  int          g1q[$];
  logic [31:0] cval;
  logic [7:0]  seen;
  int          k, dark, g1cnt;
  logic        found, hold0, hold1;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h0,         8'h00, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,         8'h00, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h89ABCDEF, 8'hFF, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'h89ABCDEF, 8'hFF, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'h89ABCDEF, 8'hFF, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'h89ABCDEF, 8'hFF, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 32'h89ABCDEF, 8'hFF, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h89ABCDEF, 8'hFF, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    data0 = 32'h0; data1 = 32'h0; mask0 = 8'h0; mask1 = 8'h0;
    rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0;
    data0_b = 32'h0F0F0F0F; data1_b = 32'hF0F0F0F0; mask0_b = 8'hFF; mask1_b = 8'hFF;
    m_rem = 0; m_n = 0; m_ptr = 1'b0; m_owner = 1'b0; m_pend = 1'b0; m_pw = 1'b0;
    m_disp = 32'h0; m_mask = 8'hFF; m_pdata = 32'h0; m_pmask = 8'h0;
    e_g0 = 1'b0; e_g1 = 1'b0; e_busy = 1'b0; e_nib = 4'h0; e_an = 8'hFF;

    // Reset and a single write from requester 0
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; req0 = tbl[i].r0; data0 = tbl[i].d0; mask0 = tbl[i].m0;
      req1 = tbl[i].r1; data1 = tbl[i].d1; mask1 = tbl[i].m1;
      cycle();
      chk("tbl_gnt0", gnt0, tbl[i].eg0);
      chk("tbl_gnt1", gnt1, tbl[i].eg1);
      chk("tbl_busy", busy, tbl[i].ebusy);
      if (i == 1) begin
        chk("rst_anode", disp_anode, 8'hFF);
        chk("rst_nibble", disp_nibble, 4'h0);
        chk("rst_owner", disp_owner, 1'b0);
      end
    end

    // Full scan of the written value: every digit lit with its own nibble
    cval = 32'h89ABCDEF;
    seen = 8'h00;
    for (int c = 0; c < 40; c++) begin
      cycle();
      for (int j = 0; j < 8; j++) begin
        if (disp_anode == ~(8'b1 << j)) begin
          seen[j] = 1'b1;
          chk("scan_nibble", disp_nibble, cval[4*j +: 4]);
        end
      end
    end
    chk("scan_all_digits", seen, 8'hFF);

    // Contention: both held from reset
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    req0 = 1'b1; data0 = 32'hCAFE0000; mask0 = 8'hFF;
    req1 = 1'b1; data1 = 32'h12345678; mask1 = 8'h0F;
    for (int c = 0; c < 11; c++) begin
      cycle();
      if (gnt0) g0q.push_back(c);
      if (gnt1) g1q.push_back(c);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_g0_count", g0q.size(), 2);
    chk("cont_g1_count", g1q.size(), 1);
    if (g0q.size() == 2 && g1q.size() == 1) begin
      chk("cont_g0_first", g0q[0], 0);
      chk("cont_g1_first", g1q[0], HC + 2);
      chk("cont_g0_second", g0q[1], 2 * (HC + 2));
    end
    wait_idle();

    // Masked write from requester 1
    req1 = 1'b1; data1 = 32'h12345678; mask1 = 8'h0F;
    cycle();
    chk("mask_gnt1", gnt1, 1'b1);
    cycle();
    req1 = 1'b0;
    cycle(); cycle();
    chk("mask_owner", disp_owner, 1'b1);
    cval = 32'h12345678;
    dark = 0;
    for (int c = 0; c < 32; c++) begin
      cycle();
      if (disp_anode == 8'hFF) dark++;
      for (int j = 0; j < 8; j++) begin
        if (disp_anode == ~(8'b1 << j)) begin
          chk("mask_low_digit", (j < 4), 1'b1);
          chk("mask_nibble", disp_nibble, cval[4*j +: 4]);
        end
      end
    end
    chk("mask_dark_cycles", dark, 16);
    wait_idle();

    // Request pulsed during HOLD is ignored
    req0 = 1'b1; data0 = 32'h0BADF00D; mask0 = 8'hFF;
    cycle(); cycle();
    req0 = 1'b0;
    cycle();
    req1 = 1'b1; data1 = 32'h55555555; mask1 = 8'hFF;
    cycle();
    req1 = 1'b0;
    g1cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (gnt1) g1cnt++;
    end
    chk("hold_pulse_no_gnt1", g1cnt, 0);

    // Reset in the GRANT cycle aborts the write
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    req0 = 1'b1; data0 = 32'hDEADBEEF; mask0 = 8'hFF;
    cycle();
    chk("abort_gnt0", gnt0, 1'b1);
    rst = 1'b1; req0 = 1'b0;
    cycle();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_gnt0_low", gnt0, 1'b0);
    req1 = 1'b1; data1 = 32'h0; mask1 = 8'hFF;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (c == 0) chk("abort_idle_regrant", gnt1, 1'b1);
      if (c == 1) req1 = 1'b0;
      chk("abort_nibble_zero", disp_nibble, 4'h0);
    end

    // HOLD_CYCLES=0 instance: grants every 2 cycles, alternating
    rst_b = 1'b1; cycle(); cycle(); rst_b = 1'b0;
    req0_b = 1'b1; req1_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      chk("h0_gnt0", gnt0_b, (c % 4) == 0);
      chk("h0_gnt1", gnt1_b, (c % 4) == 2);
      chk("h0_excl", gnt0_b & gnt1_b, 1'b0);
    end
    req0_b = 1'b0; req1_b = 1'b0;
    // Digit 7 -> 0 wrap
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      cycle();
      if (anode_b == 8'h7F) found = 1'b1;
    end
    chk("wrap_find_d7", found, 1'b1);
    for (int c = 0; c < SD; c++) cycle();
    chk("wrap_d0", anode_b, 8'hFE);

    // Randomized protocol-following traffic against the model
    rst = 1'b1; cycle(); rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
      end else begin
        rst = 1'b0;
        if (req0) begin
          if (gnt0) hold0 = 1'b1;
          else if (hold0) begin req0 = 1'b0; hold0 = 1'b0; end
          else if ($urandom_range(0, 39) == 0) req0 = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req0 = 1'b1; data0 = $urandom; mask0 = 8'($urandom);
        end
        if (req1) begin
          if (gnt1) hold1 = 1'b1;
          else if (hold1) begin req1 = 1'b0; hold1 = 1'b0; end
          else if ($urandom_range(0, 39) == 0) req1 = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req1 = 1'b1; data1 = $urandom; mask1 = 8'($urandom);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
